// File: rtl/wb_commit_queue_pkg.sv
// Shared constants for the write-back commit queue and its forwarding selector.
package wb_commit_queue_pkg;

    // Queue depth and register-file geometry used as parameter defaults.
    localparam int unsigned WB_QUEUE_DEPTH            = 4;
    localparam int unsigned REGISTER_FILE_ADDRESS_LEN = 4;
    localparam int unsigned REGISTER_FILE_LEN         = 32;
    localparam int unsigned REGISTER_FILE_SIZE        = 16;

endpackage

// File: rtl/wb_commit_queue_if.sv
// Producer/consumer bundle of the commit queue: mem and exe result handshakes,
// register-file write port, pending mask and forwarding lookup.
interface wb_commit_queue_if
    import wb_commit_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = REGISTER_FILE_ADDRESS_LEN,
    parameter int unsigned DATA_W = REGISTER_FILE_LEN,
    parameter int unsigned NREGS  = REGISTER_FILE_SIZE
) ();

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_value;
    logic              mem_ready;

    logic              exe_valid;
    logic [ADDR_W-1:0] exe_dest;
    logic [DATA_W-1:0] exe_value;
    logic              exe_ready;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;

    logic [NREGS-1:0]  pending;

    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_value;

    // Producers, register file and hazard logic sit on the master side.
    modport master (
        output mem_valid, mem_dest, mem_value,
        output exe_valid, exe_dest, exe_value,
        output fwd_addr,
        input  mem_ready, exe_ready,
        input  wb_en, wb_dest, wb_value,
        input  pending, fwd_hit, fwd_value
    );

    // The commit queue itself.
    modport slave (
        input  mem_valid, mem_dest, mem_value,
        input  exe_valid, exe_dest, exe_value,
        input  fwd_addr,
        output mem_ready, exe_ready,
        output wb_en, wb_dest, wb_value,
        output pending, fwd_hit, fwd_value
    );

endinterface

// File: rtl/wb_fwd_select.sv
// Youngest-match forwarding selector: scans queued entries from tail-1 back to
// head and returns the value of the first entry whose destination matches.
module wb_fwd_select #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [ADDR_W-1:0] dest_i  [DEPTH],
    input  logic [DATA_W-1:0] value_i [DEPTH],
    input  logic [PTR_W-1:0]  head_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [ADDR_W-1:0] fwd_addr_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_value_o
);

    logic              hit;
    logic [DATA_W-1:0] value;
    logic [CNT_W-1:0]  off;
    logic [PTR_W-1:0]  idx;

    // Priority scan, youngest first; k counts back from the newest entry.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        off   = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            off = count_i - CNT_W'(k + 1);
            idx = head_i + off[PTR_W-1:0];
            if (!hit && (CNT_W'(k) < count_i) && valid_i[idx] &&
                (dest_i[idx] == fwd_addr_i)) begin
                hit   = 1'b1;
                value = value_i[idx];
            end
        end
        fwd_hit_o   = hit;
        fwd_value_o = value;
    end

endmodule

// File: rtl/wb_commit_queue.sv
// Write-back commit queue: buffers ALU and load results in program order and
// retires one register-file write per cycle, with a pending mask and forwarding.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_QUEUE_DEPTH,
    parameter int unsigned ADDR_W = REGISTER_FILE_ADDRESS_LEN,
    parameter int unsigned DATA_W = REGISTER_FILE_LEN,
    parameter int unsigned NREGS  = REGISTER_FILE_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    wb_commit_queue_if.slave    bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CntOneFree = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CntTwoFree = CNT_W'(DEPTH - 2);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [ADDR_W-1:0] dest_d  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              mem_ready, exe_ready;
    logic              mem_fire, exe_fire, deq;
    logic [PTR_W-1:0]  exe_slot;
    logic [NREGS-1:0]  pending;

    // Readiness from registered count only; exe needs a second free slot when mem also offers.
    always_comb begin
        mem_ready = rst && (count_q <= CntOneFree);
        exe_ready = rst && (bus.mem_valid ? (count_q <= CntTwoFree) : (count_q <= CntOneFree));
        mem_fire  = bus.mem_valid && mem_ready;
        exe_fire  = bus.exe_valid && exe_ready;
        deq       = (count_q != '0);
    end

    // Next-state: pop the head, then place mem (older) at tail and exe behind it.
    always_comb begin
        valid_d  = valid_q;
        dest_d   = dest_q;
        value_d  = value_q;
        head_d   = head_q;
        exe_slot = tail_q + PTR_W'(mem_fire);
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (mem_fire) begin
            valid_d[tail_q] = 1'b1;
            dest_d[tail_q]  = bus.mem_dest;
            value_d[tail_q] = bus.mem_value;
        end
        if (exe_fire) begin
            valid_d[exe_slot] = 1'b1;
            dest_d[exe_slot]  = bus.exe_dest;
            value_d[exe_slot] = bus.exe_value;
        end
        tail_d  = tail_q + PTR_W'(mem_fire) + PTR_W'(exe_fire);
        count_d = count_q + CNT_W'(mem_fire) + CNT_W'(exe_fire) - CNT_W'(deq);
    end

    // Control state with synchronous active-low reset; reset drops all queued entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; only meaningful under the matching valid bit, so no reset.
    always_ff @(posedge clk) begin
        dest_q  <= dest_d;
        value_q <= value_d;
    end

    // Pending mask: OR of every queued destination, head included.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending[dest_q[i]] = 1'b1;
            end
        end
    end

    wb_fwd_select #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_select (
        .valid_i     (valid_q),
        .dest_i      (dest_q),
        .value_i     (value_q),
        .head_i      (head_q),
        .count_i     (count_q),
        .fwd_addr_i  (bus.fwd_addr),
        .fwd_hit_o   (bus.fwd_hit),
        .fwd_value_o (bus.fwd_value)
    );

    // Head entry drives the register-file port; zeroed when the queue is empty.
    always_comb begin
        bus.mem_ready = mem_ready;
        bus.exe_ready = exe_ready;
        bus.wb_en     = deq;
        bus.wb_dest   = deq ? dest_q[head_q]  : '0;
        bus.wb_value  = deq ? value_q[head_q] : '0;
        bus.pending   = pending;
    end

endmodule
